// File: rtl/pe_psum_tx.sv
// pe_psum_tx: multiply-accumulates K kernel rows over K columns and IN_CH
// channels, one channel per accepted beat, and emits the K row sums on PE
// together with a single-cycle in_valid pulse.
//
// Handshake: a beat moves when data_valid && data_ready are both high at a
// rising clk edge. data_ready depends only on state and rst, never on
// data_valid. Upstream must hold the beat until it is taken. in_valid has no
// backpressure and is never held or repeated.
module pe_psum_tx #(
    parameter  int IFM_BIT = 8,
    parameter  int W_BIT   = 8,
    parameter  int K       = 3,
    parameter  int IN_CH   = 512,
    localparam int BIT_PE  = IFM_BIT + W_BIT + $clog2(K * IN_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [K*K*IFM_BIT-1:0]    ifm,
    input  logic [K*K*W_BIT-1:0]      weight,
    output logic                      in_valid,
    output logic [K*BIT_PE-1:0]       PE,
    output logic [1:0]                state_dbg
);

    localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int PW = IFM_BIT + W_BIT;
    localparam logic [CW-1:0] LAST_CNT = CW'(IN_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q;
    logic signed [BIT_PE-1:0]  acc_q [K];
    logic signed [BIT_PE-1:0]  acc_d [K];
    logic                      accept;
    logic                      last_beat;

    assign data_ready = !rst && (state_q != SEND);
    assign accept     = data_valid && data_ready;
    assign last_beat  = accept && (cnt_q == LAST_CNT);
    assign state_dbg  = state_q;

    // Per-lane beat term; the first beat of a packet loads instead of adding.
    always_comb begin
        logic signed [PW-1:0]     a_ext;
        logic signed [PW-1:0]     w_ext;
        logic signed [PW-1:0]     prod;
        logic signed [BIT_PE-1:0] term;
        a_ext = '0;
        w_ext = '0;
        prod  = '0;
        term  = '0;
        for (int r = 0; r < K; r++) begin
            term = '0;
            for (int c = 0; c < K; c++) begin
                a_ext = PW'($signed(ifm[(r*K+c)*IFM_BIT +: IFM_BIT]));
                w_ext = PW'($signed(weight[(r*K+c)*W_BIT +: W_BIT]));
                prod  = a_ext * w_ext;
                term  = term + BIT_PE'(prod);
            end
            acc_d[r] = (cnt_q == '0) ? term : acc_q[r] + term;
        end
    end

    // Next-state logic: SEND lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = last_beat ? SEND : ACC;
            ACC:  if (last_beat) state_d = SEND;
            SEND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Channel counter: wraps to 0 on the last beat of a packet.
    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (accept) cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
    end

    // Row accumulators; they hold across idle gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) acc_q[r] <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) acc_q[r] <= acc_d[r];
        end
    end

    // Result register: loaded with final sums on the last beat, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid <= 1'b0;
            PE       <= '0;
        end else begin
            in_valid <= last_beat;
            for (int r = 0; r < K; r++)
                PE[r*BIT_PE +: BIT_PE] <= last_beat ? acc_d[r] : '0;
        end
    end

endmodule

// File: tb/tb_pe_psum_tx.sv
// tb_pe_psum_tx: directed and randomized checks of pe_psum_tx. Instance A uses
// IN_CH=4 and is checked against a packet-level reference model; instance B
// uses the default parameters for the large-magnitude case.
module tb_pe_psum_tx;

    localparam int K_A    = 3;
    localparam int IN_A   = 4;
    localparam int BIT_A  = 8 + 8 + $clog2(K_A * IN_A);   // 20
    localparam int IN_B   = 512;
    localparam int BIT_B  = 8 + 8 + $clog2(3 * IN_B);     // 27

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (IN_CH = 4) ----------------
    logic                 dv_a = 1'b0;
    logic                 rdy_a;
    logic [71:0]          ifm_a = '0;
    logic [71:0]          w_a = '0;
    logic                 iv_a;
    logic [3*BIT_A-1:0]   pe_a;
    logic [1:0]           st_a;

    pe_psum_tx #(.IFM_BIT(8), .W_BIT(8), .K(K_A), .IN_CH(IN_A)) dut_a (
        .clk(clk), .rst(rst), .data_valid(dv_a), .data_ready(rdy_a),
        .ifm(ifm_a), .weight(w_a), .in_valid(iv_a), .PE(pe_a),
        .state_dbg(st_a)
    );

    // ---------------- DUT B (defaults) ----------------
    logic                 dv_b = 1'b0;
    logic                 rdy_b;
    logic [71:0]          ifm_b = '0;
    logic [71:0]          w_b = '0;
    logic                 iv_b;
    logic [3*BIT_B-1:0]   pe_b;
    logic [1:0]           st_b;

    pe_psum_tx dut_b (
        .clk(clk), .rst(rst), .data_valid(dv_b), .data_ready(rdy_b),
        .ifm(ifm_b), .weight(w_b), .in_valid(iv_b), .PE(pe_b),
        .state_dbg(st_b)
    );

    // ---------------- counters and check ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint lane_a(input logic [3*BIT_A-1:0] pe, input int r);
        logic signed [BIT_A-1:0] l;
        l = pe[r*BIT_A +: BIT_A];
        return longint'(l);
    endfunction

    function automatic longint lane_b(input logic [3*BIT_B-1:0] pe, input int r);
        logic signed [BIT_B-1:0] l;
        l = pe[r*BIT_B +: BIT_B];
        return longint'(l);
    endfunction

    // ---------------- reference model (packet level) ----------------
    logic [3*BIT_A-1:0] exp_q[$];
    longint             m_sum[3];
    int                 m_beats = 0;

    task automatic model_reset();
        for (int r = 0; r < 3; r++) m_sum[r] = 0;
        m_beats = 0;
    endtask

    // One channel adds sum_c ifm[r][c]*w[r][c] to row r; after IN_A channels
    // the packet's row sums become the expected PE word.
    task automatic model_beat(input logic [71:0] i, input logic [71:0] w);
        logic signed [7:0]  x;
        logic signed [7:0]  y;
        logic [3*BIT_A-1:0] e;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                x = i[(r*3+c)*8 +: 8];
                y = w[(r*3+c)*8 +: 8];
                m_sum[r] += longint'(x) * longint'(y);
            end
        m_beats++;
        if (m_beats == IN_A) begin
            e = '0;
            for (int r = 0; r < 3; r++) e[r*BIT_A +: BIT_A] = m_sum[r][BIT_A-1:0];
            exp_q.push_back(e);
            model_reset();
        end
    endtask

    // ---------------- output monitors ----------------
    int                 pulses_a = 0;
    int                 pulse_cyc_a = 0;
    int                 pulse_prev_a = 0;
    logic [3*BIT_A-1:0] last_pe_a = '0;
    int                 pulses_b = 0;
    logic [3*BIT_B-1:0] last_pe_b = '0;

    // Every cycle: PE must be zero outside a pulse; a pulse must match the model.
    always @(negedge clk) begin
        if (iv_a === 1'b1) begin
            pulses_a++;
            pulse_prev_a = pulse_cyc_a;
            pulse_cyc_a  = cyc;
            last_pe_a    = pe_a;
            chk("a_ready_in_send", rdy_a, 0);
            chk("a_pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("a_pe_vs_model", pe_a, exp_q.pop_front());
        end else begin
            chk("a_pe_zero_idle", pe_a, 0);
        end
        if (iv_b === 1'b1) begin
            pulses_b++;
            last_pe_b = pe_b;
            chk("b_ready_in_send", rdy_b, 0);
        end else begin
            chk("b_pe_zero_idle", pe_b, 0);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [71:0] rnd72();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    function automatic logic [71:0] make_rows(input int v0, input int v1, input int v2);
        logic [71:0] x;
        int          v;
        x = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                v = (r == 0) ? v0 : (r == 1) ? v1 : v2;
                x[(r*3+c)*8 +: 8] = v[7:0];
            end
        return x;
    endfunction

    // Offer a beat at a negedge, hold it until ready, return one cycle after it is taken.
    task automatic beat_a(input logic [71:0] i, input logic [71:0] w);
        int waited = 0;
        ifm_a = i;
        w_a   = w;
        dv_a  = 1'b1;
        while (rdy_a !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("a_beat_accept_timeout", waited < 50, 1);
        if (waited < 50) model_beat(i, w);
        @(negedge clk);
    endtask

    task automatic idle_a(input int n);
        dv_a  = 1'b0;
        ifm_a = rnd72();
        w_a   = rnd72();
        repeat (n) @(negedge clk);
    endtask

    task automatic beat_b(input logic [71:0] i, input logic [71:0] w);
        int waited = 0;
        ifm_b = i;
        w_b   = w;
        dv_b  = 1'b1;
        while (rdy_b !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("b_beat_accept_timeout", waited < 50, 1);
        @(negedge clk);
    endtask

    // Hold reset for n cycles checking outputs, then release and check ready.
    task automatic reset_check(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_in_valid_a", iv_a, 0);
            chk("rst_pe_a", pe_a, 0);
            chk("rst_ready_a", rdy_a, 0);
            chk("rst_ready_b", rdy_b, 0);
        end
        rst  = 1'b0;
        dv_a = 1'b0;
        dv_b = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_rst_ready_a", rdy_a, 1);
        chk("post_rst_ready_b", rdy_b, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          p0;
        logic [71:0] ones;
        logic [71:0] twos;
        logic [71:0] fives;
        logic [71:0] neg;

        model_reset();
        ones  = make_rows(1, 1, 1);
        twos  = make_rows(2, 2, 2);
        fives = make_rows(5, 5, 5);
        neg   = make_rows(-128, -128, -128);

        // Reset from power-up.
        reset_check(5);

        // All ones x twos, back-to-back: every lane 3*2*4 = 24.
        p0 = pulses_a;
        for (int b = 0; b < IN_A; b++) beat_a(ones, twos);
        idle_a(1);
        chk("b2b_pulse_count", pulses_a - p0, 1);
        for (int r = 0; r < 3; r++) chk("b2b_lane_24", lane_a(last_pe_a, r), 24);

        // Row-distinct values with random gaps: lanes 60, -60, 180.
        p0 = pulses_a;
        for (int b = 0; b < IN_A; b++) begin
            beat_a(make_rows(1, -1, 3), fives);
            idle_a($urandom_range(0, 3));
        end
        idle_a(1);
        chk("gap_pulse_count", pulses_a - p0, 1);
        chk("gap_lane0", lane_a(last_pe_a, 0), 60);
        chk("gap_lane1", lane_a(last_pe_a, 1), -60);
        chk("gap_lane2", lane_a(last_pe_a, 2), 180);

        // Two packets with data_valid held high, second all zeros.
        p0 = pulses_a;
        for (int b = 0; b < IN_A; b++) beat_a(rnd72(), rnd72());
        for (int b = 0; b < IN_A; b++) beat_a('0, rnd72());
        idle_a(1);
        chk("cont_pulse_count", pulses_a - p0, 2);
        chk("cont_pulse_period", pulse_cyc_a - pulse_prev_a, IN_A + 1);
        for (int r = 0; r < 3; r++) chk("cont_zero_lane", lane_a(last_pe_a, r), 0);

        // Abort after two beats; reset with a beat still offered.
        p0 = pulses_a;
        beat_a(rnd72(), rnd72());
        beat_a(rnd72(), rnd72());
        ifm_a = rnd72();
        reset_check(5);
        chk("abort_no_pulse", pulses_a - p0, 0);
        for (int b = 0; b < IN_A; b++) beat_a(ones, ones);
        idle_a(1);
        chk("abort_pulse_count", pulses_a - p0, 1);
        for (int r = 0; r < 3; r++) chk("abort_lane_12", lane_a(last_pe_a, r), 12);

        // Defaults, worst-case magnitude: 3*512*16384 per lane.
        p0 = pulses_b;
        for (int b = 0; b < IN_B; b++) beat_b(neg, neg);
        dv_b = 1'b0;
        @(negedge clk);
        chk("big_pulse_count", pulses_b - p0, 1);
        for (int r = 0; r < 3; r++) chk("big_lane", lane_b(last_pe_b, r), 25165824);

        // Randomized packets with random gaps, checked against the model.
        p0 = pulses_a;
        for (int p = 0; p < 8; p++)
            for (int b = 0; b < IN_A; b++) begin
                beat_a(rnd72(), rnd72());
                if ($urandom_range(0, 1) == 1) idle_a($urandom_range(1, 3));
            end
        idle_a(2);
        chk("rand_pulse_count", pulses_a - p0, 8);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
